// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared multiply/divide op encodings for the MIPS core
package mips_pkg;

  localparam int MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_NOP   = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

  // Ops that occupy the unit for several cycles and write HI/LO at the end.
  function automatic logic md_is_long(input logic [MD_OP_W-1:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/mips_mdu.sv
// rtl/mips_mdu.sv - multi-cycle MULT/DIV unit owning the architectural HI/LO registers
module mips_mdu
  import mips_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic               cancel,
  input  logic [WIDTH-1:0]   rs_data,
  input  logic [WIDTH-1:0]   rt_data,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0]    MUL_CNT = CW'(MUL_LAT);
  localparam logic [CW-1:0]    DIV_CNT = CW'(DIV_LAT);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] sh_hi_q, sh_lo_q;
  logic             sh_wr_q;

  logic                      op_long;
  logic signed [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic                      div_zero, div_ovf;
  logic [WIDTH-1:0]          divisor_s, divisor_u;
  logic signed [WIDTH-1:0]   quo_s, rem_s;
  logic [WIDTH-1:0]          quo_u, rem_u;
  logic [WIDTH-1:0]          res_hi_d, res_lo_d;
  logic                      res_wr_d;

  assign op_long = md_is_long(md_op);

  assign prod_s = $signed({{WIDTH{rs_data[WIDTH-1]}}, rs_data})
                * $signed({{WIDTH{rt_data[WIDTH-1]}}, rt_data});
  assign prod_u = {{WIDTH{1'b0}}, rs_data} * {{WIDTH{1'b0}}, rt_data};

  // Divisor is steered to 1 for /0 and INT_MIN/-1 so the divider never sees an
  // undefined case; INT_MIN/1 already yields the required lo=INT_MIN, hi=0.
  assign div_zero  = (rt_data == '0);
  assign div_ovf   = (rs_data == INT_MIN) && (rt_data == '1);
  assign divisor_s = (div_zero || div_ovf) ? ONE_W : rt_data;
  assign divisor_u = div_zero ? ONE_W : rt_data;

  assign quo_s = $signed(rs_data) / $signed(divisor_s);
  assign rem_s = $signed(rs_data) % $signed(divisor_s);
  assign quo_u = rs_data / divisor_u;
  assign rem_u = rs_data % divisor_u;

  always_comb begin
    res_hi_d = '0;
    res_lo_d = '0;
    res_wr_d = 1'b1;
    case (md_op)
      MD_MULT:  {res_hi_d, res_lo_d} = prod_s;
      MD_MULTU: {res_hi_d, res_lo_d} = prod_u;
      MD_DIV: begin
        res_lo_d = quo_s;
        res_hi_d = rem_s;
        res_wr_d = !div_zero;
      end
      MD_DIVU: begin
        res_lo_d = quo_u;
        res_hi_d = rem_u;
        res_wr_d = !div_zero;
      end
      default:  res_wr_d = 1'b0;
    endcase
  end

  // Cancel takes priority over both a new start and a pending commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
      sh_wr_q <= 1'b0;
    end else if (cancel) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_wr_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        case (md_op)
          MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
            sh_hi_q <= res_hi_d;
            sh_lo_q <= res_lo_d;
            sh_wr_q <= res_wr_d;
            cnt_q   <= (md_op == MD_MULT || md_op == MD_MULTU) ? MUL_CNT : DIV_CNT;
            state_q <= S_RUN;
          end
          MD_MTHI: hi_q <= rs_data;
          MD_MTLO: lo_q <= rs_data;
          default: ;
        endcase
      end
    end else begin
      cnt_q <= cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        state_q <= S_IDLE;
        sh_wr_q <= 1'b0;
        if (sh_wr_q) begin
          hi_q <= sh_hi_q;
          lo_q <= sh_lo_q;
        end
      end
    end
  end

  assign busy = (state_q == S_RUN) || (start && op_long);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
